// File: rtl/singlecycle_pkg.sv
// Shared types and constants for the single-cycle RV32I core.
//   LsuState_e  : load/store unit FSM states (IDLE, REQ, RESP)
//   LSU_*       : funct3 encodings for load/store width and signedness
//   SZ_*        : access size classes derived from funct3
//   lsu_size()  : funct3 -> size class (unlisted encodings behave as word)
//   lsu_misaligned() : size class + byte offset -> misalignment flag
package singlecycle_pkg;

  localparam int unsigned LSUSTATE_W = 2;

  typedef enum logic [LSUSTATE_W-1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } LsuState_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic [1:0] lsu_size(input logic [2:0] funct3);
    logic [1:0] sz;
    case (funct3)
      LSU_B, LSU_BU: sz = SZ_B;
      LSU_H, LSU_HU: sz = SZ_H;
      default:       sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic mis;
    case (sz)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic for the load/store unit.
// Request side (from byte address, funct3, store data):
//   o_word_addr  : address bits [31:2]
//   o_off        : effective byte offset used for the access
//   o_be         : byte enables
//   o_wdata      : store data replicated across the active lanes
//   o_misaligned : access is misaligned
// Load side (from captured funct3/offset and memory read word):
//   o_ld_data    : shifted and sign/zero-extended load result
// Macro LSU_MISALIGN_CHECK_EN: when defined, misalignment is flagged;
// otherwise the flag is 0 and the offending low offset bits are cleared.
module lsu_align
  import singlecycle_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [29:0] o_word_addr,
  output logic [1:0]  o_off,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic [31:0] o_ld_data
);

  logic [1:0]  sz;
  logic [1:0]  off;
  logic [31:0] shifted;

  always_comb begin
    sz           = lsu_size(i_funct3);
    off          = i_addr[1:0];
    o_misaligned = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    o_misaligned = lsu_misaligned(sz, i_addr[1:0]);
`else
    if (sz == SZ_H) begin
      off[0] = 1'b0;
    end else if (sz == SZ_W) begin
      off = '0;
    end
`endif
    o_off       = off;
    o_word_addr = i_addr[31:2];
    o_be        = '1;
    o_wdata     = i_st_data;
    case (sz)
      SZ_B: begin
        o_be    = 4'b0001 << off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      SZ_H: begin
        o_be    = 4'b0011 << {off[1], 1'b0};
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        o_be    = '1;
        o_wdata = i_st_data;
      end
    endcase
  end

  always_comb begin
    shifted = i_rdata >> {i_ld_off, 3'b000};
    case (i_ld_funct3)
      LSU_B:   o_ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LSU_H:   o_ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LSU_BU:  o_ld_data = {24'd0, shifted[7:0]};
      LSU_HU:  o_ld_data = {16'd0, shifted[15:0]};
      default: o_ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: responder to the control unit's lsu_VALID/lsu_READY
// handshake, running one request/ack transaction on the data memory port.
// Ports:
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   lsu_VALID/READY    : access request in / one-cycle completion pulse out
//   i_st_mem, i_funct3 : store/load select, width/sign
//   i_addr, i_st_data  : byte address, store data (rs2)
//   o_ld_data          : extended load result (held after READY)
//   o_misaligned       : misaligned access flag (valid with READY)
//   o_mem_*            : memory request, write enable, word address,
//                        byte enables, write data
//   i_mem_ack/rdata    : memory completion and read word
// Macro LSU_MISALIGN_CHECK_EN enables misalignment suppression (see lsu_align).
module lsu
  import singlecycle_pkg::*;
#(
  parameter int unsigned MEM_AW = 30
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              lsu_VALID,
  output logic              lsu_READY,
  input  logic              i_st_mem,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_st_data,
  output logic [31:0]       o_ld_data,
  output logic              o_misaligned,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
);

  LsuState_e   state_q, state_d;
  logic [29:0] waddr_q, waddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        misal_q, misal_d;
  logic [31:0] ld_q, ld_d;

  logic [29:0] al_waddr;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_misal;
  logic [31:0] al_ld;

  // Request fields are decoded from the live inputs and registered at accept,
  // so memory-side outputs come straight from flops and stay stable in REQ.
  lsu_align u_align (
    .i_addr       (i_addr),
    .i_funct3     (i_funct3),
    .i_st_data    (i_st_data),
    .i_ld_funct3  (f3_q),
    .i_ld_off     (off_q),
    .i_rdata      (i_mem_rdata),
    .o_word_addr  (al_waddr),
    .o_off        (al_off),
    .o_be         (al_be),
    .o_wdata      (al_wdata),
    .o_misaligned (al_misal),
    .o_ld_data    (al_ld)
  );

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    misal_d = misal_q;
    ld_d    = ld_q;
    case (state_q)
      IDLE: begin
        if (lsu_VALID) begin
          waddr_d = al_waddr;
          be_d    = al_be;
          wdata_d = al_wdata;
          we_d    = i_st_mem;
          f3_d    = i_funct3;
          off_d   = al_off;
          misal_d = al_misal;
          if (al_misal) begin
            ld_d    = '0;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (i_mem_ack) begin
          if (!we_q) begin
            ld_d = al_ld;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      waddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      misal_q <= 1'b0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      misal_q <= misal_d;
      ld_q    <= ld_d;
    end
  end

  assign o_mem_req    = (state_q == REQ);
  assign lsu_READY    = (state_q == RESP);
  assign o_mem_we     = we_q & o_mem_req;
  assign o_mem_addr   = waddr_q[MEM_AW-1:0];
  assign o_mem_be     = be_q;
  assign o_mem_wdata  = wdata_q;
  assign o_misaligned = misal_q;
  assign o_ld_data    = ld_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the single-cycle RV32I core: the responder side of the `lsu_VALID`/`lsu_READY` handshake raised by the control unit for every load and store. It accepts the ALU-computed address, `funct3`, and store data, then runs one transaction on the data-memory request/acknowledge port. It returns sign/zero-extended load data and asserts `lsu_READY` for exactly one cycle, so the PC and the register write advance on that edge.

## Interface
- `MEM_AW`, default 30: word-address width driven on `o_mem_addr`, which carries byte address bits [31:2].
- `i_clk` in 1: core clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `lsu_VALID` in 1: access request from control; held high until `lsu_READY`.
- `lsu_READY` out 1: one-cycle completion pulse.
- `i_st_mem` in 1: 1 = store, 0 = load.
- `i_funct3` in 3: width/sign, `i_inst[14:12]`.
- `i_addr` in 32: byte address (ALU result).
- `i_st_data` in 32: rs2 value.
- `o_ld_data` out 32: extended load result; valid while `lsu_READY`=1, held afterwards.
- `o_misaligned` out 1: access misaligned; valid while `lsu_READY`=1.
- `o_mem_req` out 1: memory request.
- `o_mem_we` out 1: write enable.
- `o_mem_addr` out MEM_AW: word address.
- `o_mem_be` out 4: byte enables.
- `o_mem_wdata` out 32: lane-steered store data.
- `i_mem_ack` in 1: memory done; for a read, `i_mem_rdata` is valid in the same cycle.
- `i_mem_rdata` in 32: read word.

## Operation
FSM states and transitions:
- IDLE → REQ when `lsu_VALID`=1.
  - On that edge, capture `i_addr`, `i_funct3`, `i_st_mem`, `i_st_data`.
  - If the access is misaligned, go IDLE → RESP instead.
- REQ: `o_mem_req`=1; the request fields are driven from the captured values.
  - Stay in REQ while `i_mem_ack`=0.
  - On `i_mem_ack`=1 → RESP; loads register the extended data on that edge.
- RESP: `lsu_READY`=1 for one cycle → IDLE.
  - A `lsu_VALID` seen in the following IDLE cycle belongs to the next instruction and starts a new access.

Address and data rules:
- Word address `o_mem_addr` = addr[31:2].
- Byte enables:
  - sb: `4'b0001 << addr[1:0]`.
  - sh: `4'b0011 << {addr[1],1'b0}`.
  - sw: `4'b1111`.
- Store data: sb writes `{4{data[7:0]}}`; sh writes `{2{data[15:0]}}`; sw writes the word unchanged.
- Loads: shift rdata right by `8*addr[1:0]`, then extend:
  - `funct3` 000 (lb) / 001 (lh): sign-extend.
  - 100 (lbu) / 101 (lhu): zero-extend.
  - 010 (lw): no extension.
  - 011, 110, 111: treated as lw.
- Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0. Such an access:
  - issues no memory request;
  - returns `o_ld_data`=0 and `o_misaligned`=1.

Boundary cases:
- `i_mem_ack` outside REQ is ignored.
- `lsu_VALID` dropping while in REQ or RESP has no effect; the transaction completes.
- Reset mid-transaction: the FSM returns to IDLE immediately and `o_mem_req` drops asynchronously. The memory side must tolerate an abandoned request.

## Timing
- Reset values:
  - state IDLE;
  - `lsu_READY`, `o_misaligned`, `o_mem_req`, `o_mem_we` = 0;
  - `o_mem_addr`, `o_mem_be`, `o_mem_wdata`, `o_ld_data` = 0.
- All outputs are registered or decoded from the state register; there is no combinational path from `lsu_VALID` to any output.
- Minimum aligned latency, with `i_mem_ack` asserted in the first REQ cycle:
  - cycle 0: `lsu_VALID` accepted;
  - cycle 1: REQ with ack;
  - cycle 2: `lsu_READY` high.
  - The core stalls 2 cycles.
- Latency grows by one cycle per REQ cycle without ack.
- Misaligned access: `lsu_READY` in cycle 1.
- `o_mem_req` and all request fields stay stable from REQ entry until the ack cycle inclusive.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - misalignment is detected as above;
  - the access is suppressed and `o_misaligned` is flagged.
- Undefined:
  - `o_misaligned` is tied to 0;
  - offending low bits are forced to 0 (halfword: addr[0]; word: addr[1:0]);
  - the access always goes to memory.

## Structure
- `singlecycle_pkg` gains:
  - `LsuState_e` (IDLE, REQ, RESP);
  - funct3 constants `LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`;
  - `LSUSTATE_W`.
- Sub-module `lsu_align`, purely combinational:
  - byte-enable generation, store-data steering and misalignment detect from addr/funct3;
  - load extraction and extension from rdata.
- `lsu` holds the FSM and the capture registers.

## Test plan
- lw, addr `0x100`, ack in the first REQ cycle, rdata `0xDEADBEEF`:
  - `o_mem_addr`=`0x40`, be=`4'b1111`;
  - `lsu_READY` on cycle 2 with `o_ld_data`=`0xDEADBEEF`.
- lb at addr `0x103` with rdata `0x80FF_0000` → `o_ld_data`=`0xFFFFFF80`. lbu at the same address and rdata → `0x00000080`.
- sh at addr `0x202`, data `0x1234ABCD` → we=1, be=`4'b1100`, wdata=`0xABCDABCD`, and no change to `o_ld_data`.
- Ack delayed 3 cycles:
  - `o_mem_req` held for 3 cycles with fields stable;
  - `lsu_READY` is a single pulse one cycle after the ack;
  - back-to-back loads: the second access starts in the cycle after RESP.
- lw at addr `0x101` with `LSU_MISALIGN_CHECK_EN`:
  - no `o_mem_req`;
  - cycle 1 shows `lsu_READY`=1, `o_misaligned`=1, `o_ld_data`=0.
  - Without the macro: the access goes to word `0x40` with be=`4'b1111`.
- Assert `i_rst` while in REQ:
  - `o_mem_req` and `lsu_READY` drop immediately;
  - a late `i_mem_ack` after release is ignored;
  - the next `lsu_VALID` completes normally.
